// File: rtl/fir_filter_param_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the parametrised FIR filter: default widths, a
//   constant-evaluable ceiling-log2 and the accumulator width rule used by
//   the filter, its interface and the rounding/saturation stage.
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int DEF_NUM_TAPS  = 8;
    localparam int DEF_N1        = 8;
    localparam int DEF_N2        = 16;
    localparam int DEF_N3        = 32;
    localparam int DEF_OUT_SHIFT = 0;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Width that holds the sum of all tap products without overflow.
    function automatic int accWidth(input int n1, input int n2, input int taps);
        return n1 + n2 + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// -----------------------------------------------------------------------------
// fir_filter_param_if
//   Streaming and coefficient-load bus of the FIR filter.
//   master : sample source / controller (drives enable, samples, coefficients)
//   slave  : the filter (drives filtered output, overflow flag, debug tap)
//   Signals:
//     enable    pipeline advance, 0 freezes the datapath
//     inValid   inData carries a sample
//     inData    signed input sample (N2)
//     coefWe    write coefData into the shadow bank at coefAddr
//     coefAddr  tap index, 0 = newest sample (AW)
//     coefData  signed coefficient (N1)
//     coefSwap  one-cycle pulse, copy shadow bank into active bank
//     outValid  outData carries a new filtered sample
//     outData   signed filtered sample (N3)
//     ovf       outData was saturated (qualified by outValid)
//     sampleT   most recently accepted sample
// -----------------------------------------------------------------------------
interface fir_filter_param_if
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int N1       = DEF_N1,
    parameter int N2       = DEF_N2,
    parameter int N3       = DEF_N3
);
    localparam int AW = clog2(NUM_TAPS);

    logic                 enable;
    logic                 inValid;
    logic signed [N2-1:0] inData;
    logic                 coefWe;
    logic [AW-1:0]        coefAddr;
    logic signed [N1-1:0] coefData;
    logic                 coefSwap;
    logic                 outValid;
    logic signed [N3-1:0] outData;
    logic                 ovf;
    logic signed [N2-1:0] sampleT;

    modport master (
        output enable, inValid, inData, coefWe, coefAddr, coefData, coefSwap,
        input  outValid, outData, ovf, sampleT
    );

    modport slave (
        input  enable, inValid, inData, coefWe, coefAddr, coefData, coefSwap,
        output outValid, outData, ovf, sampleT
    );

endinterface

// File: rtl/fir_filter_param_round_sat.sv
// -----------------------------------------------------------------------------
// fir_round_sat
//   Combinational output conditioning of the FIR accumulator: optional
//   round-half-up followed by an arithmetic right shift, then clamping to the
//   signed OUT_W range.
//   Ports:
//     acc_i   signed accumulator (IN_W)
//     data_o  rounded, shifted, saturated result (OUT_W)
//     ovf_o   1 when the result had to be clamped
// -----------------------------------------------------------------------------
module fir_round_sat #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 32,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  acc_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    ovf_o
);
    // One guard bit for the rounding add, one more so the clamp limits of a
    // wide output still fit as signed values.
    localparam int W = ((IN_W + 1 > OUT_W) ? IN_W + 1 : OUT_W) + 1;

    logic signed [W-1:0] accExt;
    logic signed [W-1:0] rounded;
    logic signed [W-1:0] shifted;
    logic signed [W-1:0] maxVal;
    logic signed [W-1:0] minVal;

    assign accExt = W'(acc_i);

    generate
        if (SHIFT > 0) begin : gRound
            assign rounded = accExt + (W'(1) <<< (SHIFT - 1));
        end else begin : gNoRound
            assign rounded = accExt;
        end
    endgenerate

    assign shifted = rounded >>> SHIFT;
    assign maxVal  = W'({1'b0, {(OUT_W-1){1'b1}}});
    assign minVal  = ~maxVal;

    // Clamp to the output range; when the output is wide enough the limits
    // are never crossed and the value is simply sign-extended.
    always_comb begin
        data_o = shifted[OUT_W-1:0];
        ovf_o  = 1'b0;
        if (shifted > maxVal) begin
            data_o = maxVal[OUT_W-1:0];
            ovf_o  = 1'b1;
        end else if (shifted < minVal) begin
            data_o = minVal[OUT_W-1:0];
            ovf_o  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_filter_param.sv
// -----------------------------------------------------------------------------
// fir_filter_param
//   Pipelined direct-form FIR filter with a double-buffered, runtime-loadable
//   coefficient bank.
//   Pipeline: S0 delay line -> S1 registered products -> S2 registered sum
//             -> S3 round/saturate/output register. A sample accepted at
//   edge t produces outValid at edge t+3 while enable stays high.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    fir_filter_param_if slave modport (stream + coefficient bus)
// -----------------------------------------------------------------------------
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int NUM_TAPS  = DEF_NUM_TAPS,
    parameter int N1        = DEF_N1,
    parameter int N2        = DEF_N2,
    parameter int N3        = DEF_N3,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
    input  logic             clk,
    input  logic             rst_n,
    fir_filter_param_if.slave bus
);
    localparam int PW    = N1 + N2;
    localparam int ACC_W = accWidth(N1, N2, NUM_TAPS);

    logic signed [N2-1:0]    delayLine_q   [NUM_TAPS];
    logic signed [N1-1:0]    shadowBank_q  [NUM_TAPS];
    logic signed [N1-1:0]    activeBank_q  [NUM_TAPS];
    logic signed [PW-1:0]    product_q     [NUM_TAPS];
    logic signed [PW-1:0]    product_d     [NUM_TAPS];
    logic signed [ACC_W-1:0] sum_q;
    logic signed [ACC_W-1:0] sum_d;
    logic                    s0Valid_q;
    logic                    s1Valid_q;
    logic                    s2Valid_q;
    logic                    outValid_q;
    logic signed [N3-1:0]    outData_q;
    logic                    ovf_q;
    logic signed [N3-1:0]    satData;
    logic                    satOvf;
    logic                    coefWriteOk;
    logic                    swapNow;

    assign coefWriteOk = bus.coefWe && (int'(bus.coefAddr) < NUM_TAPS);
    assign swapNow     = bus.enable && bus.coefSwap;

    // S0: the delay line shifts only on an accepted sample; the valid bit
    // records whether the last enabled edge accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) delayLine_q[i] <= '0;
            s0Valid_q <= 1'b0;
        end else if (bus.enable) begin
            s0Valid_q <= bus.inValid;
            if (bus.inValid) begin
                delayLine_q[0] <= bus.inData;
                for (int i = 1; i < NUM_TAPS; i++) delayLine_q[i] <= delayLine_q[i-1];
            end
        end
    end

    // Coefficient banks. The shadow bank is written independent of enable.
    // A swap copies the shadow contents as they were before any write in the
    // same cycle. Because products are formed one edge after acceptance, a
    // sample accepted on the swap edge already sees the new bank while older
    // samples were multiplied with the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadowBank_q[i] <= '0;
                activeBank_q[i] <= '0;
            end
        end else begin
            if (coefWriteOk) shadowBank_q[bus.coefAddr] <= bus.coefData;
            if (swapNow)     activeBank_q <= shadowBank_q;
        end
    end

    // Tap products at full N1+N2 precision.
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            product_d[i] = PW'(activeBank_q[i]) * PW'(delayLine_q[i]);
        end
    end

    // Single-level sum of all products, sign-extended to the accumulator.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            sum_d = sum_d + ACC_W'(product_q[i]);
        end
    end

    fir_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (N3),
        .SHIFT (OUT_SHIFT)
    ) uRoundSat (
        .acc_i  (sum_q),
        .data_o (satData),
        .ovf_o  (satOvf)
    );

    // S1..S3 advance together with enable; output data and ovf only change
    // when a valid sample reaches the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) product_q[i] <= '0;
            s1Valid_q  <= 1'b0;
            sum_q      <= '0;
            s2Valid_q  <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            ovf_q      <= 1'b0;
        end else if (bus.enable) begin
            product_q  <= product_d;
            s1Valid_q  <= s0Valid_q;
            sum_q      <= sum_d;
            s2Valid_q  <= s1Valid_q;
            outValid_q <= s2Valid_q;
            if (s2Valid_q) begin
                outData_q <= satData;
                ovf_q     <= satOvf;
            end
        end
    end

    assign bus.outValid = outValid_q;
    assign bus.outData  = outData_q;
    assign bus.ovf      = ovf_q;
    assign bus.sampleT  = delayLine_q[0];

endmodule

// File: tb/tb_fir_filter_param.sv
// -----------------------------------------------------------------------------
// tb_fir_filter_param
//   Drives three filter instances with one shared stimulus stream:
//     A : N3=32, OUT_SHIFT=0 (plain output)
//     S : N3=16, OUT_SHIFT=0 (saturating output)
//     R : N3=32, OUT_SHIFT=2 (rounding output)
//   A sample-level reference (history of accepted samples, banks, queue of
//   pending results) predicts every output; directed phases add literal
//   expectations on the captured output streams.
// -----------------------------------------------------------------------------
module tb_fir_filter_param;

    localparam int NT = 8;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               inValid;
    logic signed [15:0] inData;
    logic               coefWe;
    logic [2:0]         coefAddr;
    logic signed [7:0]  coefData;
    logic               coefSwap;

    int testsRun;
    int failed;

    fir_filter_param_if #(.N3(32)) ifA ();
    fir_filter_param_if #(.N3(16)) ifS ();
    fir_filter_param_if #(.N3(32)) ifR ();

    assign ifA.enable   = enable;   assign ifS.enable   = enable;   assign ifR.enable   = enable;
    assign ifA.inValid  = inValid;  assign ifS.inValid  = inValid;  assign ifR.inValid  = inValid;
    assign ifA.inData   = inData;   assign ifS.inData   = inData;   assign ifR.inData   = inData;
    assign ifA.coefWe   = coefWe;   assign ifS.coefWe   = coefWe;   assign ifR.coefWe   = coefWe;
    assign ifA.coefAddr = coefAddr; assign ifS.coefAddr = coefAddr; assign ifR.coefAddr = coefAddr;
    assign ifA.coefData = coefData; assign ifS.coefData = coefData; assign ifR.coefData = coefData;
    assign ifA.coefSwap = coefSwap; assign ifS.coefSwap = coefSwap; assign ifR.coefSwap = coefSwap;

    fir_filter_param #(.N3(32), .OUT_SHIFT(0)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.slave));
    fir_filter_param #(.N3(16), .OUT_SHIFT(0)) dutS (.clk(clk), .rst_n(rst_n), .bus(ifS.slave));
    fir_filter_param #(.N3(32), .OUT_SHIFT(2)) dutR (.clk(clk), .rst_n(rst_n), .bus(ifR.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: accepted-sample history, both banks, pending results
    // counted down in enabled edges, and the currently expected output.
    int     hist    [NT];
    int     shadowM [NT];
    int     activeM [NT];
    longint pendAcc [$];
    int     pendLeft[$];
    bit     expValid;
    longint expAcc;
    int     expSample;
    longint modelAcc;

    // Output captures for the literal checks (one entry per produced sample).
    longint logA[$];
    longint logS[$];
    longint logR[$];
    bit     ovfS[$];

    function automatic longint roundSat(input longint acc, input int shift, input int width,
                                        output bit clipped);
        longint v;
        longint hi;
        longint lo;
        v = acc;
        if (shift > 0) v = (acc + (longint'(1) <<< (shift - 1))) >>> shift;
        hi = (longint'(1) <<< (width - 1)) - 1;
        lo = -hi - 1;
        clipped = 1'b0;
        if (v > hi) begin
            v = hi;
            clipped = 1'b1;
        end else if (v < lo) begin
            v = lo;
            clipped = 1'b1;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkDut(input string tag, input logic v, input logic signed [63:0] d,
                            input logic o, input logic signed [63:0] s,
                            input int shift, input int width);
        bit     clip;
        longint e;
        if (!rst_n) begin
            checkOutput({tag, "RstValid"},  v, 0);
            checkOutput({tag, "RstData"},   d, 0);
            checkOutput({tag, "RstOvf"},    o, 0);
            checkOutput({tag, "RstSample"}, s, 0);
        end else begin
            checkOutput({tag, "Valid"}, v, expValid);
            if (expValid) begin
                e = roundSat(expAcc, shift, width, clip);
                checkOutput({tag, "Data"}, d, e);
                checkOutput({tag, "Ovf"},  o, clip);
            end
            checkOutput({tag, "Sample"}, s, expSample);
        end
    endtask

    // Reference model, stepped on every rising edge with the stimulus that
    // the filters sample on that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) begin
                hist[i]    = 0;
                shadowM[i] = 0;
                activeM[i] = 0;
            end
            pendAcc.delete();
            pendLeft.delete();
            expValid  = 1'b0;
            expAcc    = 0;
            expSample = 0;
        end else begin
            if (enable) begin
                expValid = 1'b0;
                foreach (pendLeft[i]) pendLeft[i]--;
                if (pendLeft.size() > 0 && pendLeft[0] == 0) begin
                    expValid = 1'b1;
                    expAcc   = pendAcc.pop_front();
                    void'(pendLeft.pop_front());
                end
                if (coefSwap) activeM = shadowM;
            end
            if (coefWe && int'(coefAddr) < NT) shadowM[coefAddr] = int'(coefData);
            if (enable && inValid) begin
                for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'(inData);
                modelAcc = 0;
                for (int k = 0; k < NT; k++) modelAcc += longint'(activeM[k]) * longint'(hist[k]);
                pendAcc.push_back(modelAcc);
                pendLeft.push_back(3);
                expSample = int'(inData);
            end
        end
    end

    // Compare process: every cycle, shortly after the rising edge.
    always @(posedge clk) begin
        #2;
        checkDut("A", ifA.outValid, ifA.outData, ifA.ovf, ifA.sampleT, 0, 32);
        checkDut("S", ifS.outValid, ifS.outData, ifS.ovf, ifS.sampleT, 0, 16);
        checkDut("R", ifR.outValid, ifR.outData, ifR.ovf, ifR.sampleT, 2, 32);
        if (rst_n && enable) begin
            if (ifA.outValid) logA.push_back(ifA.outData);
            if (ifS.outValid) begin
                logS.push_back(ifS.outData);
                ovfS.push_back(ifS.ovf);
            end
            if (ifR.outValid) logR.push_back(ifR.outData);
        end
    end

    task automatic applyStimulus(input logic en, input logic iv, input logic signed [15:0] d,
                                 input logic we, input logic [2:0] a,
                                 input logic signed [7:0] cd, input logic sw);
        @(negedge clk);
        enable   = en;
        inValid  = iv;
        inData   = d;
        coefWe   = we;
        coefAddr = a;
        coefData = cd;
        coefSwap = sw;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writeAll(input int value);
        for (int k = 0; k < NT; k++) applyStimulus(1, 0, 0, 1, 3'(k), 8'(value), 0);
    endtask

    task automatic swapBank();
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic clearLogs();
        logA.delete();
        logS.delete();
        logR.delete();
        ovfS.delete();
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clearLogs();
    endtask

    initial begin
        testsRun = 0;
        failed   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        coefWe   = 1'b0;
        coefAddr = '0;
        coefData = '0;
        coefSwap = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-stream clears outputs immediately and drops in-flight work.
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 16'sd1000, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("T1AsyncValid",  ifA.outValid, 0);
        checkOutput("T1AsyncSample", ifA.sampleT,  0);
        checkOutput("T1AsyncData",   ifA.outData,  0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Impulse through coefficients 1..8.
        doReset();
        for (int k = 0; k < NT; k++) applyStimulus(1, 0, 0, 1, 3'(k), 8'(k + 1), 0);
        swapBank();
        applyStimulus(1, 1, 16'sd1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1, 1, 16'sd0, 0, 0, 0, 0);
        idle(6);
        checkOutput("T2Count", logA.size(), 8);
        for (int k = 0; k < NT; k++) checkOutput($sformatf("T2Out%0d", k), logA[k], k + 1);

        // Saturation of the 16-bit instance at both rails.
        doReset();
        writeAll(127);
        swapBank();
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 16'sd32767, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, -16'sd32768, 0, 0, 0, 0);
        idle(6);
        checkOutput("T3SatHi",    logS[7],  32767);
        checkOutput("T3OvfHi",    ovfS[7],  1);
        checkOutput("T3SatLo",    logS[15], -32768);
        checkOutput("T3OvfLo",    ovfS[15], 1);
        checkOutput("T3WideHi",   logA[7],  33291272);
        checkOutput("T3WideLo",   logA[15], -33292288);

        // Swap while streaming, including a write in the swap cycle.
        doReset();
        writeAll(1);
        swapBank();
        for (int i = 0; i < 24; i++) begin
            if (i >= 10 && i <= 17)
                applyStimulus(1, 1, 16'sd10, 1, 3'(i - 10), 8'sd2, 0);
            else if (i == 18)
                applyStimulus(1, 1, 16'sd10, 1, 3'd0, 8'sd5, 1);
            else
                applyStimulus(1, 1, 16'sd10, 0, 0, 0, i == 21);
        end
        idle(6);
        checkOutput("T4Fill",     logA[6],  70);
        checkOutput("T4OldBank",  logA[17], 80);
        checkOutput("T4SwapEdge", logA[18], 160);
        checkOutput("T4NewBank",  logA[20], 160);
        checkOutput("T4WeSwap",   logA[21], 190);

        // Five-cycle stall with in_valid held; the swap inside it is lost.
        doReset();
        writeAll(1);
        swapBank();
        writeAll(3);
        for (int n = 1; n <= 12; n++) begin
            applyStimulus(1, 1, 16'(n), 0, 0, 0, 0);
            if (n == 6)
                for (int s = 0; s < 5; s++) applyStimulus(0, 1, 16'sd7, 0, 0, 0, s == 1);
        end
        idle(6);
        checkOutput("T5Count",  logA.size(), 12);
        checkOutput("T5Out6",   logA[5],  21);
        checkOutput("T5Out12",  logA[11], 68);

        // Round-half-up with shift 2, with bubbles between samples.
        doReset();
        applyStimulus(1, 0, 0, 1, 3'd0, 8'sd1, 0);
        swapBank();
        applyStimulus(1, 1, 16'sd6, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'sd0, 0, 0, 0, 0);
        applyStimulus(1, 1, 16'sd5, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'sd0, 0, 0, 0, 0);
        applyStimulus(1, 1, -16'sd6, 0, 0, 0, 0);
        idle(6);
        checkOutput("T6Count", logR.size(), 3);
        checkOutput("T6Pos6",  logR[0], 2);
        checkOutput("T6Pos5",  logR[1], 1);
        checkOutput("T6Neg6",  logR[2], -1);

        // Randomised traffic with one reset in the middle.
        doReset();
        for (int c = 0; c < 800; c++) begin
            if (c == 400) doReset();
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                          16'($urandom), $urandom_range(0, 4) == 0, 3'($urandom),
                          8'($urandom), $urandom_range(0, 19) == 0);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", testsRun, failed);
        $finish;
    end

endmodule
